// File: rtl/exp_golomb_pkg.sv
// Shared types and sizing helpers for the order-k exp-Golomb encoder.
// EXPG_SIGNED_EN widens the internal value by one bit for the signed-to-unsigned mapping.
package exp_golomb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PREFIX = 2'd1,
      ST_SUFFIX = 2'd2
   } expg_state_e;

   function automatic int uw_f(input int data_w);
`ifdef EXPG_SIGNED_EN
      return data_w + 2;
`else
      return data_w + 1;
`endif
   endfunction

   function automatic int len_w_f(input int uw);
      return $clog2(2 * uw + 1);
   endfunction

   // Codeword length from MSB index n of u and effective order keff.
   function automatic int cw_len_f(input int n, input int keff);
      return 2 * n - keff + 1;
   endfunction

endpackage

// File: rtl/exp_golomb_enc_k_lod.sv
// Leading-one detector: returns the bit index of the most significant set bit of vec_i.
// Purely combinational; an all-zero input reports index 0.
module expg_lod #(
   parameter int UW = 9,
   parameter int NW = $clog2(UW)
) (
   input  logic [UW-1:0] vec_i,
   output logic [NW-1:0] msb_o
);

   always_comb begin
      msb_o = '0;
      for (int i = 0; i < UW; i++) begin
         if (vec_i[i]) msb_o = NW'(i);
      end
   end

endmodule

// File: rtl/exp_golomb_enc_k.sv
// Serial order-k exp-Golomb encoder, MSB-first one bit per beat; first bit one cycle after accept,
// cod_rdy_i low freezes all state, rdy_o reopens on the consumed last bit. EXPG_SIGNED_EN: signed dt_i.
module exp_golomb_enc_k
   import exp_golomb_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int K_MAX  = 3,
   localparam int KW     = $clog2(K_MAX + 1),
   localparam int UW     = uw_f(DATA_W),
   localparam int LEN_W  = len_w_f(UW)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] dt_i,
   input  logic [KW-1:0]     k_i,
   input  logic              vld_i,
   output logic              rdy_o,
   output logic              cod_o,
   output logic              cod_vld_o,
   input  logic              cod_rdy_i,
   output logic              cod_last_o,
   output logic              prc_o,
   output logic [LEN_W-1:0]  cw_len_o
);

   localparam int NW = $clog2(UW);

   localparam logic [1:0] IDLE   = 2'(ST_IDLE);
   localparam logic [1:0] PREFIX = 2'(ST_PREFIX);
   localparam logic [1:0] SUFFIX = 2'(ST_SUFFIX);

   logic [1:0]       state_q, state_d;
   logic [UW-1:0]    u_q, u_d;
   logic [NW-1:0]    idx_q, idx_d;
   logic [NW-1:0]    pcnt_q, pcnt_d;
   logic             cod_q, cod_d;
   logic             vld_q, vld_d;
   logic             last_q, last_d;
   logic             prc_q, prc_d;
   logic [LEN_W-1:0] len_q, len_d;

   logic [KW-1:0]    keff;
   logic [UW-1:0]    u_in;
   logic [NW-1:0]    n_in;
   logic [LEN_W-1:0] len_in;
   logic [NW-1:0]    idx_nx;
   logic             fire;
   logic             acc;

   always_comb begin
      keff = k_i;
      if ({1'b0, k_i} > (KW + 1)'(K_MAX)) keff = KW'(K_MAX);
   end

`ifdef EXPG_SIGNED_EN
   localparam int MW = DATA_W + 2;
   logic signed [MW-1:0] sv;
   logic        [MW-1:0] mag;

   // Zig-zag map: positives to odd codes, zero and negatives to even codes.
   assign sv   = {{2{dt_i[DATA_W-1]}}, dt_i};
   assign mag  = (sv > 0) ? MW'((sv <<< 1) - 1) : MW'(-(sv <<< 1));
   assign u_in = UW'(mag) + (UW'(1) << keff);
`else
   assign u_in = UW'(dt_i) + (UW'(1) << keff);
`endif

   expg_lod #(
      .UW (UW),
      .NW (NW)
   ) u_lod (
      .vec_i (u_in),
      .msb_o (n_in)
   );

   assign len_in = LEN_W'(cw_len_f(int'(n_in), int'(keff)));
   assign idx_nx = idx_q - NW'(1);
   assign fire   = vld_q & cod_rdy_i;
   assign rdy_o  = (state_q == IDLE) | (fire & last_q);
   assign acc    = vld_i & rdy_o;

   always_comb begin
      state_d = state_q;
      u_d     = u_q;
      idx_d   = idx_q;
      pcnt_d  = pcnt_q;
      cod_d   = cod_q;
      vld_d   = vld_q;
      last_d  = last_q;
      prc_d   = prc_q;
      len_d   = len_q;
      if (acc) begin
         // Also covers reload on the consumed last bit of the previous codeword.
         u_d   = u_in;
         idx_d = n_in;
         len_d = len_in;
         vld_d = 1'b1;
         if (n_in > NW'(keff)) begin
            state_d = PREFIX;
            pcnt_d  = n_in - NW'(keff);
            cod_d   = 1'b0;
            prc_d   = 1'b0;
            last_d  = 1'b0;
         end else begin
            state_d = SUFFIX;
            cod_d   = u_in[n_in];
            prc_d   = 1'b1;
            last_d  = (n_in == '0);
         end
      end else if (fire) begin
         case (state_q)
            PREFIX: begin
               if (pcnt_q == NW'(1)) begin
                  state_d = SUFFIX;
                  cod_d   = u_q[idx_q];
                  prc_d   = 1'b1;
                  last_d  = (idx_q == '0);
               end else begin
                  pcnt_d = pcnt_q - NW'(1);
               end
            end
            SUFFIX: begin
               if (last_q) begin
                  state_d = IDLE;
                  vld_d   = 1'b0;
                  cod_d   = 1'b0;
                  prc_d   = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  idx_d  = idx_nx;
                  cod_d  = u_q[idx_nx];
                  last_d = (idx_nx == '0);
               end
            end
            default: begin
               state_d = IDLE;
               vld_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         u_q     <= '0;
         idx_q   <= '0;
         pcnt_q  <= '0;
         cod_q   <= 1'b0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         prc_q   <= 1'b0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         u_q     <= u_d;
         idx_q   <= idx_d;
         pcnt_q  <= pcnt_d;
         cod_q   <= cod_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         prc_q   <= prc_d;
         len_q   <= len_d;
      end
   end

   assign cod_o      = cod_q;
   assign cod_vld_o  = vld_q;
   assign cod_last_o = last_q;
   assign prc_o      = prc_q;
   assign cw_len_o   = len_q;

endmodule

// File: tb/tb_exp_golomb_enc_k.sv
// Bench for exp_golomb_enc_k: directed table, back-to-back, mid-codeword reset, randomized symbols.
// Expected codewords come from plain arithmetic on the exp-Golomb definition.
module tb_exp_golomb_enc_k;
   import exp_golomb_pkg::*;

   localparam int DATA_W = 8;
   localparam int K_MAX  = 3;
   localparam int KW     = $clog2(K_MAX + 1);
   localparam int UW     = uw_f(DATA_W);
   localparam int LEN_W  = len_w_f(UW);

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] dt_i;
   logic [KW-1:0]     k_i;
   logic              vld_i;
   logic              rdy_o;
   logic              cod_o;
   logic              cod_vld_o;
   logic              cod_rdy_i;
   logic              cod_last_o;
   logic              prc_o;
   logic [LEN_W-1:0]  cw_len_o;

   exp_golomb_enc_k #(.DATA_W(DATA_W), .K_MAX(K_MAX)) dut (
      .clk        (clk),
      .rst        (rst),
      .dt_i       (dt_i),
      .k_i        (k_i),
      .vld_i      (vld_i),
      .rdy_o      (rdy_o),
      .cod_o      (cod_o),
      .cod_vld_o  (cod_vld_o),
      .cod_rdy_i  (cod_rdy_i),
      .cod_last_o (cod_last_o),
      .prc_o      (prc_o),
      .cw_len_o   (cw_len_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      int          d;
      int          k;
      logic [63:0] eb;
      int          el;
   } vec_t;

   vec_t tbl[$];
   int   cmp_cnt = 0;
   int   err_cnt = 0;
   int   cyc = 0;
   bit   bp_rand = 1'b0;

   logic q_bit[$];
   logic q_last[$];
   logic q_prc[$];
   int   q_len[$];
   int   q_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Record every beat the sink consumes (sampled mid-cycle, consumed at next posedge).
   initial forever begin
      @(negedge clk);
      if (!rst && cod_vld_o && cod_rdy_i) begin
         q_bit.push_back(cod_o);
         q_last.push_back(cod_last_o);
         q_prc.push_back(prc_o);
         q_len.push_back(int'(cw_len_o));
         q_cyc.push_back(cyc);
      end
   end

   initial begin
      cod_rdy_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cod_rdy_i = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      cmp_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h required %0h", nm, got, exp);
      end
   endtask

   function automatic void model(input logic [7:0] d, input int k, output logic [63:0] eb,
                                 output int el);
      longint v, u;
      int keff, n;
      keff = (k > K_MAX) ? K_MAX : k;
`ifdef EXPG_SIGNED_EN
      begin
         int sv;
         sv = int'($signed(d));
         v  = (sv > 0) ? longint'(2 * sv - 1) : longint'(-2 * sv);
      end
`else
      v = longint'(d);
`endif
      u = v + (longint'(1) << keff);
      n = 0;
      while ((u >> (n + 1)) != 0) n++;
      eb = 64'(u);
      el = cw_len_f(n, keff);
   endfunction

   task automatic clear_q();
      q_bit.delete();
      q_last.delete();
      q_prc.delete();
      q_len.delete();
      q_cyc.delete();
   endtask

   task automatic wait_rdy(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rdy_o) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic [KW-1:0] k, output bit ok);
      @(posedge clk);
      #1;
      dt_i  = d;
      k_i   = k;
      vld_i = 1'b1;
      wait_rdy(ok);
      vld_i = 1'b0;
   endtask

   task automatic wait_beats(input int n);
      for (int i = 0; i < 600 && q_bit.size() < n; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run_sym(input string nm, input logic [7:0] d, input logic [KW-1:0] k,
                          input logic [63:0] eb, input int el);
      bit          ok, seen1;
      logic [63:0] gv, gp, gl, ep;
      int          glen;
      clear_q();
      send(d, k, ok);
      check({nm, " accept"}, 64'(ok), 64'd1);
      check({nm, " first_bit_latency"}, 64'(cod_vld_o), 64'd1);
      wait_beats(el);
      gv = '0; gp = '0; gl = '0; ep = '0; seen1 = 1'b0; glen = el;
      for (int i = 0; i < q_bit.size(); i++) begin
         gv = {gv[62:0], q_bit[i]};
         gp = {gp[62:0], q_prc[i]};
         gl = {gl[62:0], q_last[i]};
         if (q_len[i] != el && glen == el) glen = q_len[i];
      end
      for (int i = 0; i < el; i++) begin
         if (eb[el-1-i]) seen1 = 1'b1;
         ep = {ep[62:0], seen1};
      end
      check({nm, " nbits"}, 64'(q_bit.size()), 64'(el));
      check({nm, " bits"}, gv, eb);
      check({nm, " prc"}, gp, ep);
      check({nm, " last"}, gl, 64'd1);
      check({nm, " cw_len"}, 64'(glen), 64'(el));
   endtask

   initial begin
      bit          ok;
      logic [63:0] eb1, eb2, eb;
      int          el1, el2, el;
      logic [7:0]  rd;
      int          rk;

      rst   = 1'b1;
      vld_i = 1'b0;
      dt_i  = '0;
      k_i   = '0;
      #12;
      check("reset_state", 64'({cod_o, cod_vld_o, cod_last_o, prc_o, cw_len_o, rdy_o}), 64'd1);
      @(negedge clk);
      rst = 1'b0;

`ifdef EXPG_SIGNED_EN
      tbl.push_back('{"s_neg1",   8'hFF, 0, 64'h3,   3});
      tbl.push_back('{"s_pos1",   1,     0, 64'h2,   3});
      tbl.push_back('{"s_neg128", 8'h80, 0, 64'h101, 17});
      tbl.push_back('{"s_zero",   0,     0, 64'h1,   1});
`else
      tbl.push_back('{"k0_d0",   0,   0, 64'h1,   1});
      tbl.push_back('{"k0_d3",   3,   0, 64'h4,   5});
      tbl.push_back('{"k2_d5",   5,   2, 64'h9,   5});
      tbl.push_back('{"k1_d0",   0,   1, 64'h2,   2});
      tbl.push_back('{"k3_d5",   5,   3, 64'hD,   4});
      tbl.push_back('{"k7_d5",   5,   7, 64'hD,   4});
      tbl.push_back('{"k0_d255", 255, 0, 64'h100, 17});
      tbl.push_back('{"k1_d10",  10,  1, 64'hC,   6});
`endif

      for (int pass = 0; pass < 2; pass++) begin
         bp_rand = (pass == 1);
         for (int i = 0; i < tbl.size(); i++)
            run_sym(tbl[i].nm, 8'(tbl[i].d), KW'(tbl[i].k), tbl[i].eb, tbl[i].el);
      end

      // Back-to-back: second symbol accepted on the first codeword's last beat.
      bp_rand = 1'b0;
      model(8'd3, 0, eb1, el1);
      model(8'd0, 0, eb2, el2);
      clear_q();
      @(posedge clk);
      #1;
      dt_i  = 8'd3;
      k_i   = '0;
      vld_i = 1'b1;
      wait_rdy(ok);
      check("b2b accept1", 64'(ok), 64'd1);
      dt_i = 8'd0;
      wait_rdy(ok);
      check("b2b accept2", 64'(ok), 64'd1);
      vld_i = 1'b0;
      wait_beats(el1 + el2);
      begin
         logic [63:0] gv, gl;
         gv = '0; gl = '0;
         for (int i = 0; i < q_bit.size(); i++) begin
            gv = {gv[62:0], q_bit[i]};
            gl = {gl[62:0], q_last[i]};
         end
         check("b2b nbits", 64'(q_bit.size()), 64'(el1 + el2));
         check("b2b bits", gv, (eb1 << el2) | eb2);
         check("b2b last", gl, (64'd1 << el2) | 64'd1);
         if (q_cyc.size() > 0)
            check("b2b no_gap", 64'(q_cyc[q_cyc.size()-1] - q_cyc[0]), 64'(el1 + el2 - 1));
         else
            check("b2b no_gap", 64'hFFFF, 64'(el1 + el2 - 1));
      end

      // Reset pulsed while the long codeword is in flight.
      clear_q();
      send(8'd255, '0, ok);
      check("rst accept", 64'(ok), 64'd1);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_async_outputs",
            64'({cod_o, cod_vld_o, cod_last_o, prc_o, cw_len_o, rdy_o}), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      model(8'd1, 0, eb, el);
      run_sym("after_rst_d1", 8'd1, '0, eb, el);

      // Randomized symbols with random sink backpressure.
      bp_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rd = 8'($urandom_range(0, 255));
         rk = int'($urandom_range(0, (1 << KW) - 1));
         model(rd, rk, eb, el);
         run_sym($sformatf("rand%0d_d%0d_k%0d", i, rd, rk), rd, KW'(rk), eb, el);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
